// File: rtl/seq_divider_32_pkg.sv
// Shared ALU divider definitions: FSM state encoding, default width and the
// divide-by-zero quotient pattern.
package seq_divider_32_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage : seq_divider_32_pkg

// File: rtl/seq_divider_32_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor in WIDTH+1 bits, keep the difference if it did not go negative.
module seq_divider_32_step
  import seq_divider_32_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] prem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] prem_c_o,
  output logic             qbit_c_o
);

  localparam logic [WIDTH:0] ONE_W1 = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] shifted_c;
  logic [WIDTH:0] diff_c;

  // prem < divisor keeps the shifted value below 2^(WIDTH+1), so the top bit is the sign
  assign shifted_c = {prem_i, bit_i};
  assign diff_c    = shifted_c + ~{1'b0, divisor_i} + ONE_W1;

  assign qbit_c_o = ~diff_c[WIDTH];
  assign prem_c_o = qbit_c_o ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0];

endmodule : seq_divider_32_step

// File: rtl/seq_divider_32.sv
// Iterative radix-2 restoring divider, signed/unsigned, start/busy/done handshake.
// Divides magnitudes and fixes the signs of quotient and remainder at the end.
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0]  ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? negate(x) : x;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             sgn_q, sgn_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step_prem_c;
  logic             step_qbit_c;
  logic             accept_c;

  // busy stays high through the done cycle, so start is only taken once done has dropped
  assign accept_c = start & ~busy_q;

  seq_divider_32_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .prem_i    (prem_q),
    .bit_i     (qreg_q[WIDTH-1]),
    .divisor_i (dvsr_q),
    .prem_c_o  (step_prem_c),
    .qbit_c_o  (step_qbit_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = LOAD;
      LOAD:    state_d = (dvsr_q == '0) ? FIX : RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    qreg_d  = qreg_q;
    dvsr_d  = dvsr_q;
    dvd_d   = dvd_q;
    sgn_d   = sgn_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE) || (state_q == FIX);
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          dvd_d   = dividend;
          sgn_d   = signed_op;
          dvsr_d  = magnitude(divisor, signed_op);
          q_neg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d = signed_op & dividend[WIDTH-1];
        end
      end
      LOAD: begin
        prem_d = '0;
        qreg_d = magnitude(dvd_q, sgn_q);
        cnt_d  = '0;
      end
      RUN: begin
        prem_d = step_prem_c;
        qreg_d = {qreg_q[WIDTH-2:0], step_qbit_c};
        cnt_d  = cnt_q + CNT_ONE;
      end
      FIX: begin
        done_d = 1'b1;
        if (dvsr_q == '0) begin
          quot_d = {WIDTH{DIV_ZERO_QUOT[0]}};
          rem_d  = dvd_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = q_neg_q ? negate(qreg_q) : qreg_q;
          rem_d  = r_neg_q ? negate(prem_q) : prem_q;
          dbz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      prem_q  <= '0;
      qreg_q  <= '0;
      dvsr_q  <= '0;
      dvd_q   <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      qreg_q  <= qreg_d;
      dvsr_q  <= dvsr_d;
      dvd_q   <= dvd_d;
      sgn_q   <= sgn_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : seq_divider_32

// File: tb/tb_seq_divider_32.sv
// Self-checking bench for seq_divider_32: directed vector table, handshake and
// reset corner sequences, and a short random run against a behavioural model.
module tb_seq_divider_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;
  int cyc;

  seq_divider_32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input logic sop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa;
    longint sb;
    dz = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (!sop) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  // Issue one op right after a rising edge and wait (bounded) for done.
  task automatic do_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz,
                       output int lat, output int busy_cnt);
    int t0;
    lat      = -1;
    busy_cnt = 0;
    q        = '0;
    r        = '0;
    dz       = 1'b0;
    @(posedge clk);
    #1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    t0        = cyc;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = cyc - t0;
        q   = quotient;
        r   = remainder;
        dz  = div_by_zero;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] q, r, eq, er;
    logic        dz, edz, saw_done;
    int          lat, bc, t0;
    logic        sop;
    logic [31:0] a, b;

    checks    = 0;
    failures  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs[0]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35};
    vecs[1]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 35};
    vecs[2]  = '{1'b0, 32'h1234,      32'd0,        32'hFFFF_FFFF, 32'h1234,     1'b1, 3};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 35};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 35};
    vecs[5]  = '{1'b0, 32'd0,         32'd5,        32'd0,         32'd0,        1'b0, 35};
    vecs[6]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 35};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 35};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 3};
    vecs[9]  = '{1'b0, 32'd5,         32'd10,       32'd0,         32'd5,        1'b0, 35};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,        1'b0, 35};
    vecs[11] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0,         32'h7FFF_FFFF, 1'b0, 35};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // Basic unsigned op with latency and busy-window checks
    do_op(1'b0, 32'd100, 32'd7, q, r, dz, lat, bc);
    chk("t1_quot", q, 32'd14);
    chk("t1_rem", r, 32'd2);
    chk("t1_lat", 32'(lat), 32'd35);
    chk("t1_busy_cycles", 32'(bc), 32'd35);
    @(negedge clk);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_done_pulse", 32'(done), 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].sop, vecs[i].a, vecs[i].b, q, r, dz, lat, bc);
      chk($sformatf("vec%0d_quot", i), q, vecs[i].q);
      chk($sformatf("vec%0d_rem", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // start while busy and in the done cycle must be ignored
    @(posedge clk);
    #1;
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd10;
    start     = 1'b1;
    t0        = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd77;
    divisor  = 32'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    chk("t5_lat", 32'(lat), 32'd35);
    chk("t5_quot", quotient, 32'd100);
    chk("t5_rem", remainder, 32'd0);
    chk("t5_dbz", 32'(div_by_zero), 32'd0);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("t5_done_cycle_start_busy", 32'(busy), 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t5_no_extra_done", 32'(saw_done), 32'd0);
    chk("t5_quot_held", quotient, 32'd100);
    do_op(1'b0, 32'd9, 32'd3, q, r, dz, lat, bc);
    do_op(1'b1, 32'hFFFF_FFF7, 32'd3, q, r, dz, lat, bc);
    chk("t5_b2b_quot", q, 32'hFFFF_FFFD);
    chk("t5_b2b_rem", r, 32'd0);
    chk("t5_b2b_lat", 32'(lat), 32'd35);

    // Reset in the middle of an operation
    @(posedge clk);
    #1;
    signed_op = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_quot", quotient, 32'd0);
    chk("t6_rem", remainder, 32'd0);
    chk("t6_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t6_no_done", 32'(saw_done), 32'd0);
    do_op(1'b0, 32'd50, 32'd5, q, r, dz, lat, bc);
    chk("t6_after_quot", q, 32'd10);
    chk("t6_after_rem", r, 32'd0);

    for (int n = 0; n < 200; n++) begin
      sop = 1'(n & 1);
      a   = $urandom;
      b   = $urandom;
      if ((n % 4) == 0) b = $urandom_range(0, 15);
      if ((n % 7) == 0) b = b >> $urandom_range(1, 30);
      model(sop, a, b, eq, er, edz);
      do_op(sop, a, b, q, r, dz, lat, bc);
      chk($sformatf("rnd%0d_quot", n), q, eq);
      chk($sformatf("rnd%0d_rem", n), r, er);
      chk($sformatf("rnd%0d_dbz", n), 32'(dz), 32'(edz));
      chk($sformatf("rnd%0d_lat", n), 32'(lat), edz ? 32'd3 : 32'd35);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_divider_32
